// File: rtl/div_sqrt_norm_round_tp_pkg.sv
// Shared definitions for the divide/square-root back-end: datapath widths,
// rounding modes and the packed result record carried through the output queue.
package fpu_defs_div_sqrt_tp;

  localparam int C_DIV_MANT = 23;
  localparam int C_DIV_EXP  = 7;
  localparam int C_DIV_BIAS = 127;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011
  } rm_e;

  typedef struct packed {
    logic [31:0] result;
    logic        of;
    logic        uf;
    logic        nx;
  } div_res_t;

endpackage

// File: rtl/fifo_2_tp.sv
// Generic two-entry valid/ready queue with an occupancy count, shared by the
// FPU back-ends. A push into a full queue is dropped; callers gate on count_o.
module fifo_2_tp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  assign push = push_valid_i && (count_q != 2'd2);
  assign pop  = pop_ready_i && (count_q != 2'd0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/div_sqrt_norm_round_tp.sv
// Normalize/round/pack back-end for the non-restoring divide/sqrt unit, with a
// two-entry result queue and credit-based stall toward the issuer.
module div_sqrt_norm_round_tp
  import fpu_defs_div_sqrt_tp::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   Clk_CI,
  input  logic                   Rst_RBI,
  input  logic                   Start_SI,
  input  logic                   Sign_SI,
  input  logic [2:0]             Rm_SI,
  input  logic                   Done_SI,
  input  logic [C_DIV_MANT:0]    Mant_z_DI,
  input  logic [C_DIV_EXP+1:0]   Exp_z_DI,
  input  logic [3:0]             Round_bit_DI,
  output logic                   Stall_SO,
  output logic                   Valid_SO,
  input  logic                   Ready_SI,
  output logic [31:0]            Result_DO,
  output logic                   OF_SO,
  output logic                   UF_SO,
  output logic                   NX_SO
);

  localparam int EXP_IW  = C_DIV_EXP + 3;
  localparam int EXP_OVF = 2 * C_DIV_BIAS + 1;

  logic                     sign_q, sign_d;
  rm_e                      rm_q, rm_d;
  logic                     inflight_q, inflight_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_sign_q, s1_sign_d;
  rm_e                      s1_rm_q, s1_rm_d;
  logic [C_DIV_MANT:0]      s1_mant_q, s1_mant_d;
  logic                     s1_guard_q, s1_guard_d;
  logic                     s1_sticky_q, s1_sticky_d;
  logic signed [EXP_IW-1:0] s1_exp_q, s1_exp_d;

  logic signed [EXP_IW-1:0] exp_ext;
  logic [1:0]               fifo_count;
  logic [2:0]               occupancy;
  logic                     start_ok, done_ok;
  logic [$bits(div_res_t)-1:0] fifo_head;
  div_res_t                 s2_res, head;

  // Occupancy reserves a queue slot for every op from issue until it is popped.
  assign occupancy = {1'b0, fifo_count} + {2'b0, s1_valid_q} + {2'b0, inflight_q};
  assign Stall_SO  = (occupancy >= 3'(FIFO_DEPTH));
  assign start_ok  = Start_SI && !Stall_SO;
  assign done_ok   = Done_SI && inflight_q;
  assign exp_ext   = EXP_IW'($signed(Exp_z_DI));

  always_comb begin
    sign_d      = sign_q;
    rm_d        = rm_q;
    inflight_d  = inflight_q;
    s1_valid_d  = done_ok;
    s1_sign_d   = s1_sign_q;
    s1_rm_d     = s1_rm_q;
    s1_mant_d   = s1_mant_q;
    s1_guard_d  = s1_guard_q;
    s1_sticky_d = s1_sticky_q;
    s1_exp_d    = s1_exp_q;
    if (done_ok) begin
      inflight_d = 1'b0;
      s1_sign_d  = sign_q;
      s1_rm_d    = rm_q;
      if (Mant_z_DI[C_DIV_MANT]) begin
        s1_mant_d   = Mant_z_DI;
        s1_guard_d  = Round_bit_DI[3];
        s1_sticky_d = |Round_bit_DI[2:0];
        s1_exp_d    = exp_ext;
      end else begin
        s1_mant_d   = {Mant_z_DI[C_DIV_MANT-1:0], Round_bit_DI[3]};
        s1_guard_d  = Round_bit_DI[2];
        s1_sticky_d = |Round_bit_DI[1:0];
        s1_exp_d    = exp_ext - EXP_IW'(1);
      end
    end
    // A start in the same cycle as done belongs to the next op; S1 already took the old context.
    if (start_ok) begin
      inflight_d = 1'b1;
      sign_d     = Sign_SI;
      rm_d       = rm_e'(Rm_SI);
    end
  end

  logic                     round_inc;
  logic [C_DIV_MANT+1:0]    mant_sum;
  logic [C_DIV_MANT:0]      mant_r;
  logic signed [EXP_IW-1:0] exp_r;
  logic [30:0]              max_mag, inf_mag;

  // The queue entry itself is the S2 register: rounding is computed from S1 and pushed directly.
  always_comb begin
    max_mag = 31'h7F7FFFFF;
    inf_mag = 31'h7F800000;
    case (s1_rm_q)
      RM_RTZ:  round_inc = 1'b0;
      RM_RDN:  round_inc = s1_sign_q && (s1_guard_q || s1_sticky_q);
      RM_RUP:  round_inc = !s1_sign_q && (s1_guard_q || s1_sticky_q);
      default: round_inc = s1_guard_q && (s1_sticky_q || s1_mant_q[0]);
    endcase
    mant_sum = {1'b0, s1_mant_q} + (C_DIV_MANT+2)'(round_inc);
    if (mant_sum[C_DIV_MANT+1]) begin
      mant_r = {1'b1, {C_DIV_MANT{1'b0}}};
      exp_r  = s1_exp_q + EXP_IW'(1);
    end else begin
      mant_r = mant_sum[C_DIV_MANT:0];
      exp_r  = s1_exp_q;
    end
    s2_res.of     = 1'b0;
    s2_res.uf     = 1'b0;
    s2_res.nx     = s1_guard_q || s1_sticky_q;
    s2_res.result = {s1_sign_q, exp_r[7:0], mant_r[C_DIV_MANT-1:0]};
    if (int'(exp_r) >= EXP_OVF) begin
      s2_res.of = 1'b1;
      s2_res.nx = 1'b1;
      case (s1_rm_q)
        RM_RTZ:  s2_res.result = {s1_sign_q, max_mag};
        RM_RUP:  s2_res.result = {s1_sign_q, s1_sign_q ? max_mag : inf_mag};
        RM_RDN:  s2_res.result = {s1_sign_q, s1_sign_q ? inf_mag : max_mag};
        default: s2_res.result = {s1_sign_q, inf_mag};
      endcase
    end else if (int'(exp_r) <= 0) begin
      s2_res.uf     = 1'b1;
      s2_res.nx     = 1'b1;
      s2_res.result = {s1_sign_q, 31'h0};
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      sign_q      <= 1'b0;
      rm_q        <= RM_RNE;
      inflight_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_rm_q     <= RM_RNE;
      s1_mant_q   <= '0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_exp_q    <= '0;
    end else begin
      sign_q      <= sign_d;
      rm_q        <= rm_d;
      inflight_q  <= inflight_d;
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_rm_q     <= s1_rm_d;
      s1_mant_q   <= s1_mant_d;
      s1_guard_q  <= s1_guard_d;
      s1_sticky_q <= s1_sticky_d;
      s1_exp_q    <= s1_exp_d;
    end
  end

  fifo_2_tp #(
    .WIDTH($bits(div_res_t))
  ) u_fifo (
    .clk          (Clk_CI),
    .rst_n        (Rst_RBI),
    .push_valid_i (s1_valid_q),
    .push_data_i  (s2_res),
    .pop_ready_i  (Ready_SI),
    .valid_o      (Valid_SO),
    .data_o       (fifo_head),
    .count_o      (fifo_count)
  );

  assign head      = fifo_head;
  assign Result_DO = head.result;
  assign OF_SO     = head.of;
  assign UF_SO     = head.uf;
  assign NX_SO     = head.nx;

endmodule

// File: tb/tb_div_sqrt_norm_round_tp.sv
// Directed self-checking bench for div_sqrt_norm_round_tp: rounding, special
// cases, backpressure/stall and protocol handling with hand-computed results.
module tb_div_sqrt_norm_round_tp;

  logic        clk;
  logic        rst_n;
  logic        start, sign, done, ready;
  logic [2:0]  rm;
  logic [23:0] mant;
  logic [8:0]  expz;
  logic [3:0]  rbits;
  logic        stall, valid, of_f, uf_f, nx_f;
  logic [31:0] result;

  int tests_run    = 0;
  int tests_failed = 0;
  int illegal_start_cnt = 0;
  int illegal_done_cnt  = 0;
  logic tb_inflight = 1'b0;

  typedef struct {
    string       name;
    logic        sgn;
    logic [2:0]  rmode;
    logic [23:0] m;
    logic [8:0]  e;
    logic [3:0]  rb;
    logic [31:0] res;
    logic        of;
    logic        uf;
    logic        nx;
  } vec_t;

  div_sqrt_norm_round_tp #(.FIFO_DEPTH(2)) dut (
    .Clk_CI       (clk),
    .Rst_RBI      (rst_n),
    .Start_SI     (start),
    .Sign_SI      (sign),
    .Rm_SI        (rm),
    .Done_SI      (done),
    .Mant_z_DI    (mant),
    .Exp_z_DI     (expz),
    .Round_bit_DI (rbits),
    .Stall_SO     (stall),
    .Valid_SO     (valid),
    .Ready_SI     (ready),
    .Result_DO    (result),
    .OF_SO        (of_f),
    .UF_SO        (uf_f),
    .NX_SO        (nx_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol monitor: flags issuer-side violations the DUT must ignore.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_inflight = 1'b0;
    end else begin
      if (start && stall) begin
        illegal_start_cnt++;
        $display("[TB] protocol: Start_SI while Stall_SO high at %0t", $time);
      end
      if (done && !tb_inflight) begin
        illegal_done_cnt++;
        $display("[TB] protocol: Done_SI with nothing in flight at %0t", $time);
      end
      if (done) tb_inflight = 1'b0;
      if (start && !stall) tb_inflight = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic s, input logic [2:0] r);
    start = 1'b1; sign = s; rm = r;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_op(input logic [23:0] m, input logic [8:0] e, input logic [3:0] rb);
    done = 1'b1; mant = m; expz = e; rbits = rb;
    tick();
    done = 1'b0; mant = '0; expz = '0; rbits = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; sign = 0; rm = 3'b000; done = 0; ready = 1'b1;
    mant = '0; expz = '0; rbits = '0;
    #12;
    tests_run++;
    if ({valid, stall, of_f, uf_f, nx_f} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b, expected 00000", {valid, stall, of_f, uf_f, nx_f});
    end
    tests_run++;
    if (result !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_result: got %h, expected 00000000", result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    issue(1'b0, 3'b000);
    finish_op(24'h800000, 9'd127, 4'b0000);
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL latency_done1: got Valid=%b, expected 0", valid);
    end
    tick();
    tests_run++;
    if (valid !== 1'b1 || result !== 32'h3F800000 || nx_f !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL latency_done2: got V=%b R=%h NX=%b, expected V=1 R=3f800000 NX=0",
               valid, result, nx_f);
    end
    tick();
  endtask

  task automatic test_round_pack();
    vec_t v[$];
    v.push_back('{"rne_exact",    1'b0, 3'b000, 24'h800000, 9'd127, 4'b0000, 32'h3F800000, 1'b0, 1'b0, 1'b0});
    v.push_back('{"shift_exact",  1'b0, 3'b000, 24'h7FFFFF, 9'd128, 4'b1000, 32'h3FFFFFFF, 1'b0, 1'b0, 1'b0});
    v.push_back('{"rne_tie_odd",  1'b0, 3'b000, 24'h800001, 9'd127, 4'b1000, 32'h3F800002, 1'b0, 1'b0, 1'b1});
    v.push_back('{"rne_carry",    1'b0, 3'b000, 24'hFFFFFF, 9'd127, 4'b1100, 32'h40000000, 1'b0, 1'b0, 1'b1});
    v.push_back('{"rne_tie_even", 1'b0, 3'b000, 24'h800000, 9'd127, 4'b1000, 32'h3F800000, 1'b0, 1'b0, 1'b1});
    v.push_back('{"rtz_trunc",    1'b0, 3'b001, 24'h800000, 9'd127, 4'b1111, 32'h3F800000, 1'b0, 1'b0, 1'b1});
    v.push_back('{"rdn_neg",      1'b1, 3'b010, 24'h800000, 9'd127, 4'b0001, 32'hBF800001, 1'b0, 1'b0, 1'b1});
    v.push_back('{"rup_pos",      1'b0, 3'b011, 24'h800000, 9'd127, 4'b0010, 32'h3F800001, 1'b0, 1'b0, 1'b1});
    v.push_back('{"rup_neg",      1'b1, 3'b011, 24'h800000, 9'd127, 4'b1111, 32'hBF800000, 1'b0, 1'b0, 1'b1});
    v.push_back('{"shift_round",  1'b0, 3'b000, 24'h7FFFFF, 9'd128, 4'b0110, 32'h3FFFFFFF, 1'b0, 1'b0, 1'b1});
    v.push_back('{"exp_254",      1'b0, 3'b000, 24'h800000, 9'd254, 4'b0000, 32'h7F000000, 1'b0, 1'b0, 1'b0});
    v.push_back('{"exp_1",        1'b0, 3'b000, 24'h800000, 9'd1,   4'b0000, 32'h00800000, 1'b0, 1'b0, 1'b0});
    v.push_back('{"of_rne_pos",   1'b0, 3'b000, 24'h800000, 9'd255, 4'b0000, 32'h7F800000, 1'b1, 1'b0, 1'b1});
    v.push_back('{"of_rtz_pos",   1'b0, 3'b001, 24'h800000, 9'd255, 4'b0000, 32'h7F7FFFFF, 1'b1, 1'b0, 1'b1});
    v.push_back('{"of_rne_neg",   1'b1, 3'b000, 24'h800000, 9'd255, 4'b0000, 32'hFF800000, 1'b1, 1'b0, 1'b1});
    v.push_back('{"of_rup_neg",   1'b1, 3'b011, 24'h800000, 9'd255, 4'b0000, 32'hFF7FFFFF, 1'b1, 1'b0, 1'b1});
    v.push_back('{"of_rdn_neg",   1'b1, 3'b010, 24'h800000, 9'd255, 4'b0000, 32'hFF800000, 1'b1, 1'b0, 1'b1});
    v.push_back('{"of_rdn_pos",   1'b0, 3'b010, 24'h800000, 9'd255, 4'b0000, 32'h7F7FFFFF, 1'b1, 1'b0, 1'b1});
    v.push_back('{"of_by_carry",  1'b0, 3'b000, 24'hFFFFFF, 9'd254, 4'b1100, 32'h7F800000, 1'b1, 1'b0, 1'b1});
    v.push_back('{"uf_exp0",      1'b0, 3'b000, 24'h800000, 9'd0,   4'b0000, 32'h00000000, 1'b0, 1'b1, 1'b1});
    v.push_back('{"uf_neg_exp",   1'b1, 3'b000, 24'h800000, 9'h1FD, 4'b0000, 32'h80000000, 1'b0, 1'b1, 1'b1});
    v.push_back('{"uf_by_shift",  1'b0, 3'b000, 24'h400000, 9'd1,   4'b0000, 32'h00000000, 1'b0, 1'b1, 1'b1});
    ready = 1'b1;
    foreach (v[i]) begin
      issue(v[i].sgn, v[i].rmode);
      finish_op(v[i].m, v[i].e, v[i].rb);
      tick();
      tests_run++;
      if (valid !== 1'b1 || result !== v[i].res ||
          {of_f, uf_f, nx_f} !== {v[i].of, v[i].uf, v[i].nx}) begin
        tests_failed++;
        $display("[TB] FAIL %s: got V=%b R=%h OF/UF/NX=%b%b%b, expected V=1 R=%h OF/UF/NX=%b%b%b",
                 v[i].name, valid, result, of_f, uf_f, nx_f,
                 v[i].res, v[i].of, v[i].uf, v[i].nx);
      end
    end
    tick();
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL round_drain: got Valid=%b, expected 0", valid);
    end
  endtask

  task automatic test_backpressure();
    int starts_before;
    starts_before = illegal_start_cnt;
    ready = 1'b0;
    issue(1'b0, 3'b001);
    finish_op(24'hC00000, 9'd130, 4'b0000);
    tick();
    tests_run++;
    if (valid !== 1'b1 || stall !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_one_queued: got V=%b Stall=%b, expected V=1 Stall=0", valid, stall);
    end
    issue(1'b0, 3'b000);
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_stall_inflight: got Stall=%b, expected 1", stall);
    end
    issue(1'b1, 3'b011);
    finish_op(24'h800000, 9'd128, 4'b0001);
    tick();
    tests_run++;
    if (stall !== 1'b1 || valid !== 1'b1 || result !== 32'h41400000) begin
      tests_failed++;
      $display("[TB] FAIL bp_full: got Stall=%b V=%b R=%h, expected Stall=1 V=1 R=41400000",
               stall, valid, result);
    end
    issue(1'b0, 3'b000);
    tests_run++;
    if (stall !== 1'b1 || illegal_start_cnt - starts_before !== 2) begin
      tests_failed++;
      $display("[TB] FAIL bp_blocked_start: got Stall=%b illegal=%0d, expected Stall=1 illegal=2",
               stall, illegal_start_cnt - starts_before);
    end
    ready = 1'b1;
    #1;
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_stall_during_pop: got Stall=%b, expected 1", stall);
    end
    tick();
    tests_run++;
    if (valid !== 1'b1 || result !== 32'h40000000 || nx_f !== 1'b1 || stall !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_second_head: got V=%b R=%h NX=%b Stall=%b, expected V=1 R=40000000 NX=1 Stall=0",
               valid, result, nx_f, stall);
    end
    tick();
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_drained: got Valid=%b, expected 0", valid);
    end
    issue(1'b0, 3'b000);
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_credit_after_drain: got Stall=%b, expected 0", stall);
    end
    finish_op(24'h800000, 9'd127, 4'b0000);
    tick();
    tick();
  endtask

  task automatic test_protocol();
    int dones_before;
    dones_before = illegal_done_cnt;
    finish_op(24'h800000, 9'd127, 4'b0000);
    tick();
    tick();
    tests_run++;
    if (valid !== 1'b0 || stall !== 1'b0 || illegal_done_cnt - dones_before !== 1) begin
      tests_failed++;
      $display("[TB] FAIL stray_done: got V=%b Stall=%b illegal=%0d, expected V=0 Stall=0 illegal=1",
               valid, stall, illegal_done_cnt - dones_before);
    end
  endtask

  task automatic test_reset_mid_op();
    ready = 1'b0;
    issue(1'b0, 3'b000);
    finish_op(24'h800000, 9'd127, 4'b0000);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (valid !== 1'b0 || stall !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_async: got V=%b Stall=%b, expected V=0 Stall=0", valid, stall);
    end
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    tests_run++;
    if (valid !== 1'b0 || stall !== 1'b0 || result !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_after: got V=%b Stall=%b R=%h, expected V=0 Stall=0 R=00000000",
               valid, stall, result);
    end
    ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_round_pack();
    test_backpressure();
    test_protocol();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
